// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and line levels.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic LINE_IDLE      = 1'b1;
    localparam logic LINE_STOP      = 1'b1;
    localparam logic LINE_START     = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and asynchronous read of the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doWr;
    logic             doRd;
    logic [CNT_W-1:0] countNext;

    // full/empty are the registered flags, so a write while full is dropped even if a pop happens
    assign doWr = wrEn && !full;
    assign doRd = rdEn && !empty;

    always_comb begin
        countNext = count;
        if (doWr && !doRd) begin
            countNext = count + CNT_W'(1);
        end else if (!doWr && doRd) begin
            countNext = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doWr) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doRd) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= countNext;
            full  <= (countNext == CNT_W'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (doWr) begin
            mem[wrPtr] <= wrData;
        end
    end

    assign rdData = mem[rdPtr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and drain LSB first at CLKS_PER_BIT clocks per bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       dataIn,
    input  logic             wrEn,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             busy,
    output logic             txOut
);

    localparam int                TMR_W    = $clog2(CLKS_PER_BIT);
    localparam int                BIT_W    = $clog2(UART_DATA_BITS);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    txState_t                    state;
    txState_t                    stateNext;
    logic [TMR_W-1:0]            timer;
    logic [TMR_W-1:0]            timerNext;
    logic [BIT_W-1:0]            bitIdx;
    logic [BIT_W-1:0]            bitIdxNext;
    logic [UART_DATA_BITS-1:0]   shiftReg;
    logic [UART_DATA_BITS-1:0]   shiftNext;
    logic [UART_DATA_BITS-1:0]   fifoData;
    logic                        pop;
    logic                        txNext;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wrEn),
        .wrData (dataIn),
        .rdEn   (pop),
        .rdData (fifoData),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_comb begin
        stateNext  = state;
        timerNext  = timer;
        bitIdxNext = bitIdx;
        shiftNext  = shiftReg;
        pop        = 1'b0;
        txNext     = LINE_IDLE;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shiftNext  = fifoData;
                    timerNext  = TMR_LOAD;
                    bitIdxNext = '0;
                    stateNext  = START;
                end
            end
            START: begin
                txNext = LINE_START;
                if (timer == '0) begin
                    timerNext = TMR_LOAD;
                    stateNext = DATA;
                end else begin
                    timerNext = timer - TMR_W'(1);
                end
            end
            DATA: begin
                txNext = shiftReg[0];
                if (timer == '0) begin
                    timerNext = TMR_LOAD;
                    shiftNext = {1'b0, shiftReg[UART_DATA_BITS-1:1]};
                    if (bitIdx == LAST_BIT) begin
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdx + BIT_W'(1);
                    end
                end else begin
                    timerNext = timer - TMR_W'(1);
                end
            end
            STOP: begin
                txNext = LINE_STOP;
                if (timer == '0) begin
                    // chain straight into the next start bit when more data is waiting
                    if (!empty) begin
                        pop        = 1'b1;
                        shiftNext  = fifoData;
                        timerNext  = TMR_LOAD;
                        bitIdxNext = '0;
                        stateNext  = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    timerNext = timer - TMR_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bitIdx   <= '0;
            txOut    <= LINE_IDLE;
            overflow <= 1'b0;
        end else begin
            state    <= stateNext;
            timer    <= timerNext;
            bitIdx   <= bitIdxNext;
            txOut    <= txNext;
            overflow <= overflow | (wrEn & full);
        end
    end

    always_ff @(posedge clk) begin
        shiftReg <= shiftNext;
    end

    assign busy = (state != IDLE);

endmodule
